// File: rtl/image_block_loader.sv
// Fetches an N x N feature map from external memory in BEAT-pixel beats and writes it beat by beat into the local image buffer.
// Optional macro LOADER_ZERO_TAIL_EN: final partial beat zero-pads unused lanes and writes them with a full mask.
module image_block_loader #(
  parameter int DATA_W      = 16,
  parameter int BEAT        = 25,
  parameter int ADDR_W      = 20,
  parameter int IMG_SIZE_W  = 6,
  parameter int DEPTH_BEATS = 64,
  parameter int ADDR_STRIDE = 25
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [IMG_SIZE_W-1:0]          img_size,
  input  logic [ADDR_W-1:0]              initial_addr,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic                           mem_req,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic                           mem_valid,
  input  logic [BEAT*DATA_W-1:0]         mem_data,
  output logic                           buf_we,
  output logic [$clog2(DEPTH_BEATS)-1:0] buf_waddr,
  output logic [BEAT*DATA_W-1:0]         buf_wdata,
  output logic [BEAT-1:0]                buf_wmask
);

  localparam int BW = $clog2(DEPTH_BEATS);
  localparam int PW = 2 * IMG_SIZE_W;
  localparam int DW = BEAT * DATA_W;
  localparam logic [PW-1:0] BEAT_P  = PW'(BEAT);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH_BEATS);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FETCH, S_FIN} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [IMG_SIZE_W-1:0] r_img_size;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [PW-1:0]         r_total;
  logic [PW-1:0]         r_last;
  logic [BW-1:0]         r_beat_cnt;
  logic                  r_err;
  logic                  r_we;
  logic [BW-1:0]         r_waddr;
  logic [DW-1:0]         r_wdata;
  logic [BEAT-1:0]       r_wmask;

  logic [PW-1:0]   w_pixels;
  logic [PW-1:0]   w_total;
  logic [PW-1:0]   w_last;
  logic            w_overflow;
  logic            w_final;
  logic [BEAT-1:0] w_tail_mask;
  logic [BEAT-1:0] w_final_mask;
  logic [DW-1:0]   w_beat_data;

  assign w_pixels   = PW'(r_img_size) * PW'(r_img_size);
  assign w_total    = (w_pixels / BEAT_P) + PW'(w_pixels % BEAT_P != '0);
  assign w_last     = w_pixels - (w_total - PW'(1)) * BEAT_P;
  assign w_overflow = w_total > DEPTH_P;
  assign w_final    = PW'(r_beat_cnt) == (r_total - PW'(1));

  genvar gi;
  generate
    for (gi = 0; gi < BEAT; gi++) begin : g_mask
      assign w_tail_mask[gi] = r_last > PW'(gi);
    end
  endgenerate

`ifdef LOADER_ZERO_TAIL_EN
  logic [DW-1:0] w_tail_data;
  generate
    for (gi = 0; gi < BEAT; gi++) begin : g_zero
      assign w_tail_data[gi*DATA_W +: DATA_W] =
        w_tail_mask[gi] ? mem_data[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate
  assign w_beat_data  = w_final ? w_tail_data : mem_data;
  assign w_final_mask = '1;
`else
  assign w_beat_data  = mem_data;
  assign w_final_mask = w_tail_mask;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    mem_req      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_pixels == '0 || w_overflow) w_state_next = S_FIN;
        else                              w_state_next = S_FETCH;
      end
      S_FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_valid && w_final) w_state_next = S_FIN;
      end
      S_FIN: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Buffer write port is registered: each beat lands one cycle after its mem_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_img_size <= '0;
      r_mem_addr <= '0;
      r_total    <= '0;
      r_last     <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_img_size <= img_size;
            r_mem_addr <= initial_addr;
            r_err      <= 1'b0;
          end
        end
        S_CALC: begin
          r_total    <= w_total;
          r_last     <= w_last;
          r_beat_cnt <= '0;
          if (w_overflow) r_err <= 1'b1;
        end
        S_FETCH: begin
          if (mem_valid) begin
            r_we       <= 1'b1;
            r_waddr    <= r_beat_cnt;
            r_wdata    <= w_beat_data;
            r_wmask    <= w_final ? w_final_mask : '1;
            r_mem_addr <= r_mem_addr + ADDR_W'(ADDR_STRIDE);
            r_beat_cnt <= r_beat_cnt + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign err       = r_err;
  assign mem_addr  = r_mem_addr;
  assign buf_we    = r_we;
  assign buf_waddr = r_waddr;
  assign buf_wdata = r_wdata;
  assign buf_wmask = r_wmask;

endmodule

// File: tb/tb_image_block_loader.sv
// Scoreboard bench for image_block_loader: a memory responder serves address-derived beats,
// a reference model queues expected buffer writes and done events, a monitor pops and compares.
module tb_image_block_loader;

  localparam int DATA_W = 16;
  localparam int BEAT   = 25;
  localparam int ADDR_W = 20;
  localparam int ISW    = 6;
  localparam int DEPTH  = 64;
  localparam int STRIDE = 25;
  localparam int DW     = BEAT * DATA_W;
  localparam int BW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ISW-1:0]    img_size = '0;
  logic [ADDR_W-1:0] initial_addr = '0;
  logic              busy, done, err, mem_req, buf_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid = 1'b0;
  logic [DW-1:0]     mem_data = '0;
  logic [BW-1:0]     buf_waddr;
  logic [DW-1:0]     buf_wdata;
  logic [BEAT-1:0]   buf_wmask;

  image_block_loader #(
    .DATA_W(DATA_W), .BEAT(BEAT), .ADDR_W(ADDR_W), .IMG_SIZE_W(ISW),
    .DEPTH_BEATS(DEPTH), .ADDR_STRIDE(STRIDE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .img_size(img_size),
    .initial_addr(initial_addr), .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid),
    .mem_data(mem_data), .buf_we(buf_we), .buf_waddr(buf_waddr),
    .buf_wdata(buf_wdata), .buf_wmask(buf_wmask)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BW-1:0]   waddr;
    logic [DW-1:0]   data;
    logic [BEAT-1:0] mask;
  } wr_t;

  wr_t  exp_w[$];
  logic exp_d[$];
  int   checks = 0;
  int   failures = 0;

  int          gap_mode = 0;
  int          gap_left = 0;
  logic [31:0] salt = 0;
  int          last_valid_iv = 0;
  int          done_count = 0, wr_count = 0, req_cycles = 0;
  int          first_req_iv = 0, done_iv = 0, start_iv = 0;
  bit          req_seen = 0;
  wr_t         mon_w;
  logic        mon_e;

  function automatic logic [DW-1:0] beat_of(input logic [ADDR_W-1:0] a, input logic [31:0] s);
    logic [DW-1:0] d;
    for (int i = 0; i < BEAT; i++) d[i*DATA_W +: DATA_W] = 16'(32'(a) * 3 + 32'(i) * 257 + s);
    return d;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory: serves the beat belonging to mem_addr; junk valids while no request is pending.
  always @(negedge clk) begin
    if (rst) begin
      mem_valid = 1'b0;
      gap_left  = 0;
    end else if (mem_req) begin
      if (gap_left > 0) begin
        gap_left--;
        mem_valid = 1'b0;
      end else begin
        mem_valid     = 1'b1;
        mem_data      = beat_of(mem_addr, salt);
        last_valid_iv = cyc;
        gap_left      = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 3 : int'($urandom_range(0, 2));
      end
    end else begin
      mem_valid = ($urandom_range(0, 3) == 0);
      mem_data  = DW'({13{$urandom}});
      gap_left  = (gap_mode == 0) ? 0 : 1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT writes the buffer or pulses done.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) begin
        req_cycles++;
        if (!req_seen) begin
          req_seen     = 1;
          first_req_iv = cyc;
          check("busy_at_req", DW'(busy), DW'(1));
        end
      end
      if (buf_we) begin
        wr_count++;
        if (exp_w.size() == 0) check("unexpected_write", DW'(buf_we), DW'(0));
        else begin
          mon_w = exp_w.pop_front();
          check("waddr", DW'(buf_waddr), DW'(mon_w.waddr));
          check("wdata", buf_wdata, mon_w.data);
          check("wmask", DW'(buf_wmask), DW'(mon_w.mask));
        end
      end
      if (done) begin
        done_iv = cyc;
        done_count++;
        if (exp_d.size() == 0) check("unexpected_done", DW'(done), DW'(0));
        else begin
          mon_e = exp_d.pop_front();
          check("err_at_done", DW'(err), DW'(mon_e));
          check("busy_at_done", DW'(busy), DW'(0));
        end
      end
    end
  end

  task automatic model_load(input logic [ISW-1:0] n, input logic [ADDR_W-1:0] addr,
                            output int beats, output bit ovf);
    int  px, last;
    wr_t e;
    px    = int'(n) * int'(n);
    beats = (px + BEAT - 1) / BEAT;
    ovf   = beats > DEPTH;
    last  = px - (beats - 1) * BEAT;
    if (px > 0 && !ovf) begin
      for (int k = 0; k < beats; k++) begin
        e.waddr = BW'(k);
        e.data  = beat_of(addr + ADDR_W'(k * STRIDE), salt);
        e.mask  = '1;
        if (k == beats - 1 && last < BEAT) begin
`ifdef LOADER_ZERO_TAIL_EN
          for (int i = last; i < BEAT; i++) e.data[i*DATA_W +: DATA_W] = '0;
`else
          e.mask = BEAT'((26'(1) << last) - 26'(1));
`endif
        end
        exp_w.push_back(e);
      end
    end else begin
      beats = 0;
    end
    exp_d.push_back(ovf);
  endtask

  task automatic issue_start(input logic [ISW-1:0] n, input logic [ADDR_W-1:0] addr);
    @(negedge clk);
    start        = 1'b1;
    img_size     = n;
    initial_addr = addr;
    start_iv     = cyc;
    @(negedge clk);
    start        = 1'b0;
    img_size     = ISW'($urandom);
    initial_addr = ADDR_W'($urandom);
  endtask

  task automatic run_load(input logic [ISW-1:0] n, input logic [ADDR_W-1:0] addr,
                          input int gm, input bit mid_start);
    int beats, dc0;
    bit ovf;
    gap_mode   = gm;
    salt       = $urandom;
    model_load(n, addr, beats, ovf);
    req_seen   = 0;
    req_cycles = 0;
    wr_count   = 0;
    dc0        = done_count;
    issue_start(n, addr);
    for (int t = 0; t < 3000 && done_count == dc0; t++) begin
      if (mid_start && t == 8) begin
        start    = 1'b1;
        img_size = 6'd3;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    if (done_count == dc0) begin
      check("done_timeout", DW'(done_count), DW'(dc0 + 1));
      exp_w.delete();
      exp_d.delete();
    end else begin
      @(negedge clk);
      if (beats > 0) begin
        check("req_latency", DW'(first_req_iv - start_iv), DW'(2));
        check("done_latency", DW'(done_iv - last_valid_iv), DW'(1));
      end else begin
        check("nofetch_done_latency", DW'(done_iv - start_iv), DW'(2));
        check("no_mem_req", DW'(req_cycles), DW'(0));
      end
      check("write_count", DW'(wr_count), DW'(beats));
      check("queue_drained", DW'(exp_w.size()), DW'(0));
      check("err_sticky", DW'(err), DW'(ovf));
      check("one_done", DW'(done_count), DW'(dc0 + 1));
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic reset_mid_load();
    int beats, dc0;
    bit ovf;
    gap_mode = 1;
    salt     = $urandom;
    model_load(6'd10, 20'h02000, beats, ovf);
    wr_count = 0;
    req_seen = 0;
    issue_start(6'd10, 20'h02000);
    for (int t = 0; t < 200 && wr_count == 0; t++) @(negedge clk);
    check("first_write_before_rst", DW'(wr_count), DW'(1));
    #2 rst = 1'b1;
    #1;
    check("rst_ctrl_outputs",
          DW'({busy, done, err, mem_req, mem_addr, buf_we, buf_waddr, buf_wmask}), DW'(0));
    check("rst_wdata", buf_wdata, DW'(0));
    exp_w.delete();
    exp_d.delete();
    dc0 = done_count;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("no_done_after_rst", DW'(done_count), DW'(dc0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs",
          DW'({busy, done, err, mem_req, mem_addr, buf_we, buf_waddr, buf_wmask}), DW'(0));
    check("reset_wdata", buf_wdata, DW'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_load(6'd5,  20'h00100, 1, 0);
    run_load(6'd7,  20'h00000, 0, 0);
    run_load(6'd0,  20'h00055, 0, 0);
    run_load(6'd63, 20'h00010, 0, 0);
    run_load(6'd5,  20'h00300, 2, 0);
    run_load(6'd10, 20'h00400, 1, 1);
    reset_mid_load();
    run_load(6'd5,  20'h00500, 0, 0);
    run_load(6'd40, 20'hFFFF0, 2, 0);
    run_load(6'd41, 20'h00020, 0, 0);
    run_load(6'd1,  20'hFFFFF, 0, 0);
    for (int r = 0; r < 15; r++)
      run_load(ISW'($urandom_range(0, 42)), ADDR_W'($urandom), int'($urandom_range(0, 2)), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
